gaplus_sharemem_arb: RTL and testbench
======================================

Name: gaplus_sharemem_arb

Overview:
- Parametrised shared-RAM block for N CPU ports.
- Single-clock dual-port RAM with a round-robin request/acknowledge arbiter on the CPU side.
- Independent read-only video/sprite scan port on the same clock.
- Sits between the CPUs and the tile/sprite renderer; replaces fixed two-CPU select-line muxing with fair, handshaked access.

Parameters:
- NPORTS, 2, number of CPU requesters (2..8).
- AW, 16, CPU address width.
- DW, 8, data width.
- RAM_AW, 12, RAM address width (depth 2**RAM_AW).
- WIN_BASE, 0, value of addr[AW-1:RAM_AW] that selects the RAM window.
- OPEN_BUS, 8'hFF, read data returned for out-of-window reads (DW bits).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  NPORTS  per-port access request (level).
- we  in  NPORTS  per-port write enable, qualified by req.
- addr  in  NPORTS*AW  packed port addresses; port i at [i*AW +: AW].
- wdata  in  NPORTS*DW  packed write data.
- rdata  out  NPORTS*DW  packed per-port read data, held until that port's next ack.
- ack  out  NPORTS  one-cycle completion pulse per port.
- vaddr  in  RAM_AW  video scan address.
- vdata  out  DW  video read data.

Behaviour:
- One clock; reset is asynchronous and active-high, on clk/reset.
- Reset values:
  - state=IDLE, ack=0, every rdata lane=OPEN_BUS, vdata=0.
  - rr pointer=NPORTS-1, so port 0 wins first.
  - RAM contents are not cleared.
- Handshake:
  - Port raises req with addr/we/wdata stable and holds them until its ack pulse.
  - Port must drop req (or present a new access) in the ack cycle.
  - A port whose ack is high is masked from arbitration for that cycle.
- FSM IDLE -> ACCESS -> DONE -> IDLE:
  - IDLE: if any unmasked req, grant the first requester searching from rr+1 modulo NPORTS. Latch gnt index, addr, we, wdata; rr<=gnt; go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: in-window (addr[AW-1:RAM_AW]==WIN_BASE) write commits to RAM[addr[RAM_AW-1:0]] at this edge; in-window read registers RAM data. Go to DONE.
  - DONE: rdata[gnt]<=read data, or OPEN_BUS if out-of-window, or unchanged for writes. ack[gnt]<=1 for exactly one cycle; go to IDLE.
- Out-of-window writes are discarded but still acked.
- Latency and throughput:
  - req sampled at edge t (IDLE) -> ack high in the cycle after edge t+2; rdata valid in the same cycle.
  - Maximum throughput is one access per 3 cycles; ungranted requests wait.
- Fairness: with all ports requesting continuously, grants rotate 0,1,..,NPORTS-1,0 with no port skipped.
- req dropped by a port before its grant: that port is ignored. Dropped after grant: the access still completes and acks.
- Video port:
  - vdata<=RAM[vaddr] every edge; 1-cycle latency; never stalls.
  - Unaffected by arbitration.
  - Same-edge collision with a CPU write returns old data (read-before-write).
- Reset mid-operation:
  - FSM returns to IDLE and ack clears immediately.
  - A write not yet committed at the ACCESS edge is lost.
  - Already-written RAM contents persist.
- Widths: the RAM index always uses addr[RAM_AW-1:0]. Window compare width is AW-RAM_AW; RAM_AW==AW means always in window.

Decomposition:
- Shared package gaplus_sharemem_pkg:
  - state enum (IDLE/ACCESS/DONE).
  - OPEN_BUS default.
  - helper function for the round-robin next-index search.
- One sub-module, gaplus_dpram_1w2r: write+read port A and read-only port B, both on clk, read-before-write. Inferred BRAM.
- Arbiter/FSM stays in the top module.

Test Plan:
- Port0 writes 8'h5A to 16'h0123, then reads it -> ack 3 cycles after each req; rdata[0]=8'h5A. Video read of vaddr 12'h123 gives 8'h5A one cycle later.
- Ports 0 and 1 request in the same cycle after reset -> port0 acked first, port1 acked 3 cycles later. Continuous requests from both alternate 0,1,0,1.
- NPORTS=3, all requesting continuously for 12 accesses -> grant order 0,1,2,0,1,2,...; each port gets 4 acks.
- Port1 reads 16'hF000 (out of window, WIN_BASE=0) -> ack; rdata[1]=8'hFF. A write to 16'hF000 leaves RAM unchanged.
- CPU writes 8'hAA to 12'h010 (old 8'h11) while vaddr=12'h010 at the commit edge -> vdata=8'h11 that cycle, 8'hAA next cycle.
- Assert reset during ACCESS of a pending write -> ack stays 0, state IDLE, RAM location keeps its old value. Reissued request completes normally.

Source files
------------

// File: rtl/gaplus_sharemem_pkg.sv
// gaplus_sharemem_pkg: shared FSM state type, open-bus default and round-robin search helper
package gaplus_sharemem_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  localparam logic [7:0] OPEN_BUS_DFLT = 8'hFF;
  // Scans last+n down to last+1 so the final hit is the nearest requester after last.
  function automatic logic [2:0] rr_next(input logic [7:0] reqs, input logic [2:0] last, input int n);
    logic [2:0] idx;
    rr_next = last;
    for (int k = n; k >= 1; k--) begin
      idx = 3'((int'(last) + k) % n);
      if (reqs[idx]) rr_next = idx;
    end
  endfunction
endpackage

// File: rtl/gaplus_dpram_1w2r.sv
// gaplus_dpram_1w2r: inferred dual-port RAM, port A read/write, port B read-only, read-before-write
// clk/reset, en_a/we_a/addr_a/wdata_a -> q_a, addr_b -> q_b (q_b cleared by reset)
module gaplus_dpram_1w2r #(
  parameter int AW = 12,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en_a,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] wdata_a,
  output logic [DW-1:0] q_a,
  input  logic [AW-1:0] addr_b,
  output logic [DW-1:0] q_b
);
  logic [DW-1:0] r_mem [2**AW];
  always_ff @(posedge clk) begin
    if (en_a) begin
      q_a <= r_mem[addr_a];
      if (we_a) r_mem[addr_a] <= wdata_a;
    end
  end
  always_ff @(posedge clk or posedge reset)
    q_b <= reset ? '0 : r_mem[addr_b];
endmodule

// File: rtl/gaplus_sharemem_arb.sv
// gaplus_sharemem_arb: shared RAM with round-robin CPU arbiter and free-running video read port
// req/we/addr/wdata per CPU port -> rdata/ack; vaddr -> vdata one cycle later
module gaplus_sharemem_arb
  import gaplus_sharemem_pkg::*;
#(
  parameter int NPORTS = 2,
  parameter int AW = 16,
  parameter int DW = 8,
  parameter int RAM_AW = 12,
  parameter int WIN_BASE = 0,
  parameter logic [DW-1:0] OPEN_BUS = DW'(OPEN_BUS_DFLT)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NPORTS-1:0]    req,
  input  logic [NPORTS-1:0]    we,
  input  logic [NPORTS*AW-1:0] addr,
  input  logic [NPORTS*DW-1:0] wdata,
  output logic [NPORTS*DW-1:0] rdata,
  output logic [NPORTS-1:0]    ack,
  input  logic [RAM_AW-1:0]    vaddr,
  output logic [DW-1:0]        vdata
);
  localparam int IW = $clog2(NPORTS);
  state_t r_state;
  logic [IW-1:0] r_gnt, r_rr;
  logic [AW-1:0] r_addr;
  logic r_we;
  logic [DW-1:0] r_wdata;
  logic [NPORTS-1:0] w_req;
  logic [IW-1:0] w_nxt;
  logic [DW-1:0] w_qa;
  logic w_inwin;
  // A port still seeing its ack is finishing and must not be granted again this cycle.
  assign w_req = req & ~ack;
  assign w_nxt = IW'(rr_next(8'(w_req), 3'(r_rr), NPORTS));
  if (AW == RAM_AW) begin : g_full
    assign w_inwin = 1'b1;
  end else begin : g_win
    assign w_inwin = r_addr[AW-1:RAM_AW] == (AW-RAM_AW)'(WIN_BASE);
  end
  gaplus_dpram_1w2r #(.AW(RAM_AW), .DW(DW)) u_ram (
    .clk(clk), .reset(reset),
    .en_a(r_state == ACCESS), .we_a(r_we & w_inwin),
    .addr_a(r_addr[RAM_AW-1:0]), .wdata_a(r_wdata), .q_a(w_qa),
    .addr_b(vaddr), .q_b(vdata)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      ack <= '0;
      rdata <= {NPORTS{OPEN_BUS}};
      r_rr <= IW'(NPORTS-1);
      r_gnt <= '0;
      r_addr <= '0;
      r_we <= 1'b0;
      r_wdata <= '0;
    end else begin
      ack <= '0;
      case (r_state)
        IDLE: if (|w_req) begin
          r_gnt <= w_nxt;
          r_rr <= w_nxt;
          r_addr <= addr[w_nxt*AW +: AW];
          r_we <= we[w_nxt];
          r_wdata <= wdata[w_nxt*DW +: DW];
          r_state <= ACCESS;
        end
        ACCESS: r_state <= DONE;
        DONE: begin
          if (!r_we) rdata[r_gnt*DW +: DW] <= w_inwin ? w_qa : OPEN_BUS;
          ack[r_gnt] <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gaplus_sharemem_arb.sv
// tb_gaplus_sharemem_arb: randomized self-checking bench against a behavioural shared-RAM model
module tb_gaplus_sharemem_arb;
  import gaplus_sharemem_pkg::*;
  localparam int NP = 3, AW = 16, DW = 8, RAW = 12;
  logic clk = 0, reset = 1;
  logic [NP-1:0] req = '0, we = '0;
  logic [NP*AW-1:0] addr = '0;
  logic [NP*DW-1:0] wdata = '0, rdata;
  logic [NP-1:0] ack;
  logic [RAW-1:0] vaddr = '0;
  logic [DW-1:0] vdata;
  int n_cmp = 0, n_bad = 0;
  logic [7:0] mem_m [4096];
  logic [7:0] lane_m [NP];
  int last_g;
  logic cur_w [NP];
  logic [15:0] cur_a [NP];
  logic [7:0] cur_d [NP];

  gaplus_sharemem_arb #(.NPORTS(NP), .AW(AW), .DW(DW), .RAM_AW(RAW)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .vaddr(vaddr), .vdata(vdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic inwin(logic [15:0] a);
    return a[15:12] == 4'h0;
  endfunction

  function automatic logic [NP*DW-1:0] lanes_packed();
    logic [NP*DW-1:0] v;
    for (int i = 0; i < NP; i++) v[i*DW +: DW] = lane_m[i];
    return v;
  endfunction

  task automatic set_port(int p, logic w, logic [15:0] a, logic [7:0] d);
    req[p] = 1'b1; we[p] = w; addr[p*AW +: AW] = a; wdata[p*DW +: DW] = d;
    cur_w[p] = w; cur_a[p] = a; cur_d[p] = d;
  endtask

  task automatic model_apply(int p);
    if (cur_w[p]) begin
      if (inwin(cur_a[p])) mem_m[cur_a[p][11:0]] = cur_d[p];
    end else lane_m[p] = inwin(cur_a[p]) ? mem_m[cur_a[p][11:0]] : 8'hFF;
    last_g = p;
  endtask

  task automatic single(string nm, int p, logic w, logic [15:0] a, logic [7:0] d);
    int lat = 0;
    set_port(p, w, a, d);
    do begin tick(); lat++; end while (ack[p] !== 1'b1 && lat < 20);
    n_cmp++;
    if (lat != 3) begin n_bad++; $display("FAIL %s latency: got %0d cycles, want 3", nm, lat); end
    model_apply(p);
    n_cmp++;
    if (rdata !== lanes_packed()) begin n_bad++; $display("FAIL %s rdata: got %h, want %h", nm, rdata, lanes_packed()); end
    req[p] = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    reset = 1; tick(); tick(); reset = 0;
    for (int i = 0; i < NP; i++) lane_m[i] = 8'hFF;
    last_g = NP - 1;
    n_cmp++; if (ack !== '0) begin n_bad++; $display("FAIL reset_ack: got %b, want 0", ack); end
    n_cmp++; if (rdata !== lanes_packed()) begin n_bad++; $display("FAIL reset_rdata: got %h, want %h", rdata, lanes_packed()); end
    n_cmp++; if (vdata !== 8'h00) begin n_bad++; $display("FAIL reset_vdata: got %h, want 00", vdata); end
    tick();
  endtask

  task automatic test_two_ports;
    int t0 = -1, t1 = -1;
    set_port(0, 1'b1, 16'h0020, 8'h01);
    set_port(1, 1'b1, 16'h0021, 8'h02);
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (ack[0] === 1'b1) begin t0 = c; model_apply(0); req[0] = 1'b0; end
      if (ack[1] === 1'b1) begin t1 = c; model_apply(1); req[1] = 1'b0; end
    end
    n_cmp++; if (t0 != 3) begin n_bad++; $display("FAIL two_ports_ack0: got cycle %0d, want 3", t0); end
    n_cmp++; if (t1 != 6) begin n_bad++; $display("FAIL two_ports_ack1: got cycle %0d, want 6", t1); end
  endtask

  task automatic test_init;
    for (int a = 0; a < 32; a++)
      single("init_write", a % NP, 1'b1, 16'(a), (a == 16) ? 8'h11 : 8'($urandom));
  endtask

  task automatic test_basic;
    single("basic_write", 0, 1'b1, 16'h0123, 8'h5A);
    single("basic_read", 0, 1'b0, 16'h0123, 8'h00);
    n_cmp++; if (rdata[7:0] !== 8'h5A) begin n_bad++; $display("FAIL basic_rdata0: got %h, want 5a", rdata[7:0]); end
    single("basic_read_pair", 2, 1'b0, 16'h0020, 8'h00);
    vaddr = 12'h123; tick();
    n_cmp++; if (vdata !== 8'h5A) begin n_bad++; $display("FAIL basic_vdata: got %h, want 5a", vdata); end
  endtask

  task automatic rand_access(int p);
    logic [15:0] a = {11'h000, 5'($urandom)};
    if ($urandom_range(0, 5) == 0) a[15:12] = 4'hF;
    set_port(p, 1'($urandom), a, 8'($urandom));
  endtask

  task automatic test_fair(logic [NP-1:0] mask, int count);
    int got = 0, cyc = 0, prev = 0, expg;
    int cnt [NP];
    for (int p = 0; p < NP; p++) begin cnt[p] = 0; if (mask[p]) rand_access(p); end
    while (got < count && cyc < 3 * count + 30) begin
      tick(); cyc++;
      n_cmp++;
      if ($countones(ack) > 1) begin n_bad++; $display("FAIL fair_onehot: got ack %b, want at most one bit", ack); end
      for (int p = 0; p < NP; p++) if (ack[p] === 1'b1) begin
        expg = last_g;
        for (int k = NP; k >= 1; k--) if (mask[(last_g + k) % NP]) expg = (last_g + k) % NP;
        n_cmp++; if (p != expg) begin n_bad++; $display("FAIL fair_order: got port %0d, want %0d", p, expg); end
        n_cmp++; if (cyc - prev != 3) begin n_bad++; $display("FAIL fair_interval: got %0d cycles, want 3", cyc - prev); end
        model_apply(p);
        n_cmp++; if (rdata !== lanes_packed()) begin n_bad++; $display("FAIL fair_rdata: got %h, want %h", rdata, lanes_packed()); end
        prev = cyc; got++; cnt[p]++;
        if (got < count) rand_access(p);
      end
    end
    req = '0;
    n_cmp++; if (got != count) begin n_bad++; $display("FAIL fair_timeout: got %0d acks, want %0d", got, count); end
    for (int p = 0; p < NP; p++) if (mask == '1) begin
      n_cmp++; if (cnt[p] != count / NP) begin n_bad++; $display("FAIL fair_share port %0d: got %0d acks, want %0d", p, cnt[p], count / NP); end
    end
    tick(); tick();
  endtask

  task automatic test_out_of_window;
    single("oow_read", 1, 1'b0, 16'hF000, 8'h00);
    n_cmp++; if (rdata[15:8] !== 8'hFF) begin n_bad++; $display("FAIL oow_rdata1: got %h, want ff", rdata[15:8]); end
    single("oow_write", 1, 1'b1, 16'hF000, 8'h77);
    single("oow_check", 0, 1'b0, 16'h0000, 8'h00);
    vaddr = 12'h000; tick();
    n_cmp++; if (vdata !== mem_m[0]) begin n_bad++; $display("FAIL oow_vdata: got %h, want %h", vdata, mem_m[0]); end
  endtask

  task automatic test_collision;
    single("coll_prep", 0, 1'b1, 16'h0010, 8'h11);
    vaddr = 12'h010;
    set_port(0, 1'b1, 16'h0010, 8'hAA);
    tick(); tick();
    n_cmp++; if (vdata !== 8'h11) begin n_bad++; $display("FAIL coll_old: got %h, want 11", vdata); end
    tick();
    n_cmp++; if (vdata !== 8'hAA) begin n_bad++; $display("FAIL coll_new: got %h, want aa", vdata); end
    n_cmp++; if (ack[0] !== 1'b1) begin n_bad++; $display("FAIL coll_ack: got %b, want 1", ack[0]); end
    model_apply(0); req[0] = 1'b0; tick();
  endtask

  task automatic test_reset_mid;
    single("rst_prep", 0, 1'b1, 16'h0015, 8'h5C);
    set_port(0, 1'b1, 16'h0015, 8'h3C);
    tick();
    reset = 1; #1;
    for (int i = 0; i < NP; i++) lane_m[i] = 8'hFF;
    last_g = NP - 1;
    n_cmp++; if (ack !== '0) begin n_bad++; $display("FAIL rst_mid_ack: got %b, want 0", ack); end
    n_cmp++; if (dut.r_state !== IDLE) begin n_bad++; $display("FAIL rst_mid_state: got %0d, want %0d", dut.r_state, IDLE); end
    n_cmp++; if (rdata !== lanes_packed()) begin n_bad++; $display("FAIL rst_mid_rdata: got %h, want %h", rdata, lanes_packed()); end
    req = '0; tick(); tick();
    n_cmp++; if (ack !== '0) begin n_bad++; $display("FAIL rst_mid_ack_hold: got %b, want 0", ack); end
    reset = 0; tick();
    single("rst_mid_old", 0, 1'b0, 16'h0015, 8'h00);
    n_cmp++; if (rdata[7:0] !== 8'h5C) begin n_bad++; $display("FAIL rst_mid_keep: got %h, want 5c", rdata[7:0]); end
    single("rst_mid_rewrite", 0, 1'b1, 16'h0015, 8'h3C);
    single("rst_mid_new", 0, 1'b0, 16'h0015, 8'h00);
    n_cmp++; if (rdata[7:0] !== 8'h3C) begin n_bad++; $display("FAIL rst_mid_reissue: got %h, want 3c", rdata[7:0]); end
  endtask

  initial begin
    for (int i = 0; i < NP; i++) begin cur_w[i] = 0; cur_a[i] = '0; cur_d[i] = '0; end
    test_reset();
    test_two_ports();
    test_init();
    test_basic();
    test_fair(3'b011, 8);
    test_fair(3'b111, 12);
    test_out_of_window();
    test_collision();
    test_fair(3'b111, 24);
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
